// File: rtl/mult8_seq_accum.sv
// mult8_seq_accum: sequential 8x8 unsigned multiplier built around one external 4x4
// multiplier. Each operand pair is split into nibbles and the four nibble products are
// issued one per step. Each returned partial product is shift-accumulated into a 16-bit
// result, which is then returned through a valid/ready handshake.
//
// Parameters:
//   MUL_LAT   cycles from stable mul_a/mul_b to a valid mul_p (0 = combinational, 0..3)
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake, a/b captured on acceptance
//   out_valid/out_ready result handshake, p = a*b held while out_valid
//   mul_a/mul_b/mul_p   nibble operands to and product from the 4x4 multiplier
//   busy                high while an operation is calculating or waiting to be taken
//   op_count            completed output handshakes, wraps silently
module mult8_seq_accum #(
    parameter int unsigned MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p,
    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [1:0] LatLast = MUL_LAT[1:0];

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] op_count_q, op_count_d;

    logic [3:0]  nib_a, nib_b;
    logic [3:0]  shamt;
    logic [15:0] partial;

    // Nibble selection and weight for the current step.
    always_comb begin
        nib_a = a_q[3:0];
        nib_b = b_q[3:0];
        shamt = 4'd0;
        unique case (idx_q)
            2'd0: begin nib_a = a_q[3:0]; nib_b = b_q[3:0]; shamt = 4'd0; end
            2'd1: begin nib_a = a_q[3:0]; nib_b = b_q[7:4]; shamt = 4'd4; end
            2'd2: begin nib_a = a_q[7:4]; nib_b = b_q[3:0]; shamt = 4'd4; end
            2'd3: begin nib_a = a_q[7:4]; nib_b = b_q[7:4]; shamt = 4'd8; end
            default: ;
        endcase
        partial = {8'b0, mul_p} << shamt;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        op_count_d = op_count_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'h0;
                    idx_d   = 2'd0;
                    wcnt_d  = 2'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // mul_p is only looked at on the last cycle of a step, so anything the
                // multiplier drives while its pipeline fills never reaches acc.
                if (wcnt_q != LatLast) begin
                    wcnt_d = wcnt_q + 2'd1;
                end else begin
                    acc_d  = acc_q + partial;
                    wcnt_d = 2'd0;
                    if (idx_q == 2'd3) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            wcnt_q     <= 2'd0;
            acc_q      <= 16'h0;
            a_q        <= 8'h0;
            b_q        <= 8'h0;
            op_count_q <= 16'h0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wcnt_q     <= wcnt_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_count_q <= op_count_d;
        end
    end

    // All outputs decode directly from flops; no input-to-output paths.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        p         = (state_q == StDone) ? acc_q : 16'h0;
        mul_a     = (state_q == StCalc) ? nib_a : 4'h0;
        mul_b     = (state_q == StCalc) ? nib_b : 4'h0;
        op_count  = op_count_q;
    end

endmodule

// File: tb/tb_mult8_seq_accum.sv
module tb_mult8_seq_accum;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = 8'h0;
    logic [7:0]  b = 8'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] p;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        busy;
    logic [15:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;
    int ops     = 0;

    mult8_seq_accum #(.MUL_LAT(LAT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Behavioural 4x4 multiplier with LAT cycles of latency: until its inputs have been
    // stable for LAT edges it returns random junk.
    logic [7:0]  last_ab = 8'h0;
    int unsigned age = 0;
    logic [7:0]  junk = 8'h5a;
    bit          fault_en = 1'b0;
    logic [7:0]  prod;
    int unsigned age_eff;

    always_comb begin
        prod = {4'b0, mul_a} * {4'b0, mul_b};
        if (fault_en && mul_a == 4'h1 && mul_b == 4'h1) prod = prod + 8'd1;
        age_eff = ({mul_a, mul_b} != last_ab) ? 0 : age;
        mul_p = (age_eff >= LAT) ? prod : junk;
    end

    always @(posedge clk) begin
        if ({mul_a, mul_b} != last_ab) begin
            last_ab <= {mul_a, mul_b};
            age     <= 1;
        end else if (age < 15) begin
            age <= age + 1;
        end
        junk <= 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_p"},         32'(p),         32'd0);
        check({tag, "_mul_ab"},    32'({mul_a, mul_b}), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_op_count"},  32'(op_count),  32'd0);
    endtask

    // One full operation starting at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic [15:0] exp_p, input int stall);
        int         edges;
        logic [7:0] seen[$];
        logic [3:0] na [4];
        logic [3:0] nb [4];
        na[0] = op_a[3:0]; nb[0] = op_b[3:0];
        na[1] = op_a[3:0]; nb[1] = op_b[7:4];
        na[2] = op_a[7:4]; nb[2] = op_b[3:0];
        na[3] = op_a[7:4]; nb[3] = op_b[7:4];

        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = op_a;
        b         = op_b;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        edges    = 0;
        forever begin
            check("busy_calc", 32'({busy, in_ready}), 32'b10);
            seen.push_back({mul_a, mul_b});
            // Operands offered while busy must be ignored.
            in_valid = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid) break;
            if (edges > 64) break;
        end
        check("latency", 32'(edges), 32'(4 * (LAT + 1)));
        check("seq_len", 32'(seen.size()), 32'(4 * (LAT + 1)));
        for (int i = 0; i < seen.size() && i < 4 * (LAT + 1); i++) begin
            check("mul_seq", 32'(seen[i]), 32'({na[i / (LAT + 1)], nb[i / (LAT + 1)]}));
        end
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            check("p_hold",  32'(p),         32'(exp_p));
            check("ov_hold", 32'(out_valid), 32'd1);
            check("ir_hold", 32'(in_ready),  32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("p",         32'(p),         32'(exp_p));
        check("out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        ops++;
        check("ov_drop",       32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready),  32'd1);
        check("busy_clear",    32'(busy),      32'd0);
        check("op_count",      32'(op_count),  32'(ops[15:0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] corner [6];
        logic [7:0] ra;
        logic [7:0] rb;
        corner[0] = 8'h00; corner[1] = 8'hFF; corner[2] = 8'h0F;
        corner[3] = 8'hF0; corner[4] = 8'h01; corner[5] = 8'h80;

        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        do_op(8'hFF, 8'hFF, 16'hFE01, 0);
        do_op(8'd173, 8'd59, 16'd10207, 0);
        do_op(8'd3, 8'd5, 16'd15, 10);

        // Reset in the middle of the third step.
        in_valid = 1'b1;
        a        = 8'd200;
        b        = 8'd100;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2 * (LAT + 1) + 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("idx2_operands", 32'({mul_a, mul_b}), 32'({4'hC, 4'h4}));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset_held");
        rst_n = 1'b1;
        ops   = 0;
        @(negedge clk);
        do_op(8'd2, 8'd3, 16'd6, 0);

        // Faulty high-nibble product proves mul_p is weighted by 256.
        fault_en = 1'b1;
        do_op(8'h10, 8'h10, 16'h0200, 1);
        fault_en = 1'b0;

        for (int n = 0; n < 300; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ra = corner[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) rb = corner[$urandom_range(0, 5)];
            do_op(ra, rb, 16'(ra * rb), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
